ysyx_23060332_wbu: RTL and testbench
====================================

# ysyx_23060332_wbu

Write-back unit sitting between the EXU/LSU and the two-read/one-write register file. It accepts one retiring instruction per handshake, waits for load data from memory when needed, and performs sign/zero extension. It then drives the register file write port (`waddr`/`wdata`/`reg_wen`) for exactly one cycle, together with a commit pulse. It also exports the pending destination register so the IDU can stall on read-after-write hazards.

## Interface
- `RESET_PC`, 32'h8000_0000, value `commit_pc` holds after reset
- `clk`  in  1  single system clock, all state on rising edge
- `rst`  in  1  reset, asynchronous, active-low (0 = reset)
- `in_valid`  in  1  EXU presents a retiring instruction
- `in_ready`  out  1  WBU can accept; transfer when `in_valid && in_ready`
- `in_rd`  in  5  destination register
- `in_wen`  in  1  instruction writes `rd`
- `in_is_load`  in  1  result comes from memory, not ALU
- `in_load_op`  in  3  funct3: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu
- `in_addr_lo`  in  2  load address bits [1:0]
- `in_alu_data`  in  32  ALU/CSR/link result
- `in_pc`  in  32  instruction PC
- `mem_rvalid`  in  1  load data valid (single-cycle pulse)
- `mem_rdata`  in  32  aligned 32-bit memory word
- `waddr`  out  5  register file write address
- `wdata`  out  32  register file write data
- `reg_wen`  out  1  register file write enable
- `commit_valid`  out  1  one-cycle retire pulse
- `commit_pc`  out  32  PC of retiring instruction
- `pend_valid`  out  1  a register write is outstanding
- `pend_rd`  out  5  its destination

## Operation
- FSM states: IDLE, WAIT_LOAD, WRITE.
- `in_ready` = (state != WAIT_LOAD). The WBU accepts in IDLE and in WRITE, which allows back-to-back instructions.
- On accept, latch `rd`, `wen`, `load_op`, `addr_lo` and `pc`.
  - Non-load: latch `wdata_r = in_alu_data` and go to WRITE.
  - Load: go to WAIT_LOAD.
- WAIT_LOAD: on `mem_rvalid`, write the extracted value to `wdata_r` and go to WRITE. Otherwise hold.
- WRITE:
  - `reg_wen = wen_r && (rd_r != 0)`.
  - `commit_valid = 1`.
  - `waddr = rd_r`, `wdata = wdata_r`, `commit_pc = pc_r`.
  - Next state: new accept → WRITE (non-load) or WAIT_LOAD (load); no accept → IDLE.
- Load extraction from `mem_rdata`:
  - lb/lbu: byte `addr_lo`, sign-extended for lb, zero-extended for lbu.
  - lh/lhu: halfword selected by `addr_lo[1]`; `addr_lo[0]` is ignored (misaligned access is not handled here).
  - lw and undefined codes: full word.
- `mem_rvalid` is ignored in IDLE and WRITE, and in the same cycle a load is accepted. No error is flagged.
- `rd == 0` with `wen == 1`: `reg_wen` stays 0, but the commit still occurs.
- `pend_valid` = (state != IDLE) && `wen_r` && (`rd_r` != 0). `pend_rd` = `rd_r`.
- `waddr`, `wdata` and `commit_pc` hold their last values outside WRITE. `reg_wen` and `commit_valid` are 0 outside WRITE.

## Timing
- Reset values (asynchronous, immediate on `rst` = 0):
  - state IDLE.
  - `reg_wen`, `commit_valid`, `pend_valid` = 0.
  - `waddr`, `pend_rd` = 0; `wdata` = 0.
  - `commit_pc` = `RESET_PC`.
  - `in_ready` = 1 after reset releases; inputs are ignored while `rst` = 0.
- Non-load latency: accepted at cycle N → `reg_wen`/`commit_valid` high in N+1. The register file sees the new value from N+2.
- Load latency: accepted at N, `mem_rvalid` at M ≥ N+1 → write in M+1.
- Throughput: one non-load per cycle sustained. A load blocks `in_ready` from the cycle after its accept until `mem_rvalid` arrives.
- Reset during WAIT_LOAD: the pending load is abandoned with no write and no commit. A late `mem_rvalid` arriving in IDLE is ignored.
- All outputs are driven from registered state, except `in_ready`, which is a combinational decode of state.

## Test plan
- Reset then ALU op `rd`=5, data 0x1234_5678, pc 0x8000_0000 → next cycle `reg_wen`=1, `waddr`=5, `wdata`=0x1234_5678, `commit_pc`=0x8000_0000, one-cycle pulse.
- Three back-to-back ALU ops (`rd` 1,2,3) with `in_valid` held → `in_ready` stays 1 and three consecutive single-cycle writes occur in order.
- lb at `addr_lo`=3 with `mem_rdata`=0x80FF_0000, `mem_rvalid` 2 cycles later → `in_ready`=0 while waiting, then `wdata`=0xFFFF_FF80. Repeat as lbu → 0x0000_0080. lhu at `addr_lo`=2 → 0x0000_80FF.
- ALU op with `rd`=0, `wen`=1 → `reg_wen`=0, `commit_valid`=1, `pend_valid`=0 throughout.
- lw accepted, `rst` pulsed low during WAIT_LOAD, then `mem_rvalid` → no `reg_wen`, no commit, state IDLE, `commit_pc`=`RESET_PC`.
- Load to `rd`=7 pending → `pend_valid`=1, `pend_rd`=7 from the cycle after accept through the WRITE cycle, then 0.

Source files
------------

// File: rtl/ysyx_23060332_wbu.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_23060332_wbu
// Purpose  : Write-back unit. Accepts one retiring instruction per handshake,
//            waits for load data when needed, and sign/zero-extends it. It
//            then drives the register-file write port and a commit pulse for
//            exactly one cycle. It also exports the pending destination so
//            the decoder can stall on read-after-write hazards.
// Ports    : clk, rst (async, active-low)
//            in_*      : retiring instruction from EXU/LSU (valid/ready)
//            mem_*     : load return data (single-cycle rvalid pulse)
//            waddr/wdata/reg_wen : register-file write port
//            commit_valid/commit_pc : retire pulse and its PC
//            pend_valid/pend_rd : outstanding register write
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_23060332_wbu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_rd,
  input  logic        in_wen,
  input  logic        in_is_load,
  input  logic [2:0]  in_load_op,
  input  logic [1:0]  in_addr_lo,
  input  logic [31:0] in_alu_data,
  input  logic [31:0] in_pc,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic [4:0]  waddr,
  output logic [31:0] wdata,
  output logic        reg_wen,
  output logic        commit_valid,
  output logic [31:0] commit_pc,
  output logic        pend_valid,
  output logic [4:0]  pend_rd
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_LOAD = 2'd1,
    WRITE     = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [4:0]  rd_r;
  logic        wen_r;
  logic [2:0]  load_op_r;
  logic [1:0]  addr_lo_r;
  logic [31:0] pc_r;

  logic        accept;
  logic        write_alu;
  logic        write_load;
  logic [4:0]  rd_next;
  logic        wen_next;
  logic        pend_next;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;

  assign in_ready = (state != WAIT_LOAD);
  assign accept   = in_valid && in_ready;
  assign pend_rd  = rd_r;

  // Byte/halfword lane selection; addr_lo[0] is deliberately ignored for
  // halfwords since misaligned accesses are resolved upstream.
  always_comb begin
    byte_sel = mem_rdata[7:0];
    case (addr_lo_r)
      2'd0:    byte_sel = mem_rdata[7:0];
      2'd1:    byte_sel = mem_rdata[15:8];
      2'd2:    byte_sel = mem_rdata[23:16];
      default: byte_sel = mem_rdata[31:24];
    endcase
    half_sel = addr_lo_r[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (load_op_r)
      3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_data = {24'd0, byte_sel};
      3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_data = {16'd0, half_sel};
      default: load_data = mem_rdata;
    endcase
  end

  // Next-state decode. Accept is possible in IDLE and WRITE, which gives
  // back-to-back retirement of non-load instructions.
  always_comb begin
    state_next = state;
    write_alu  = 1'b0;
    write_load = 1'b0;
    case (state)
      IDLE, WRITE: begin
        if (accept) begin
          if (in_is_load) begin
            state_next = WAIT_LOAD;
          end else begin
            state_next = WRITE;
            write_alu  = 1'b1;
          end
        end else begin
          state_next = IDLE;
        end
      end
      WAIT_LOAD: begin
        if (mem_rvalid) begin
          state_next = WRITE;
          write_load = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Pending-destination view as it will be after this edge, so pend_valid
  // is a plain register output.
  always_comb begin
    rd_next   = accept ? in_rd  : rd_r;
    wen_next  = accept ? in_wen : wen_r;
    pend_next = (state_next != IDLE) && wen_next && (rd_next != 5'd0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Write-port registers load only when entering WRITE, so they hold their
  // last values in every other state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_r         <= 5'd0;
      wen_r        <= 1'b0;
      load_op_r    <= 3'd0;
      addr_lo_r    <= 2'd0;
      pc_r         <= RESET_PC;
      waddr        <= 5'd0;
      wdata        <= 32'd0;
      reg_wen      <= 1'b0;
      commit_valid <= 1'b0;
      commit_pc    <= RESET_PC;
      pend_valid   <= 1'b0;
    end else begin
      if (accept) begin
        rd_r      <= in_rd;
        wen_r     <= in_wen;
        load_op_r <= in_load_op;
        addr_lo_r <= in_addr_lo;
        pc_r      <= in_pc;
      end
      reg_wen      <= 1'b0;
      commit_valid <= 1'b0;
      if (write_alu) begin
        reg_wen      <= in_wen && (in_rd != 5'd0);
        commit_valid <= 1'b1;
        waddr        <= in_rd;
        wdata        <= in_alu_data;
        commit_pc    <= in_pc;
      end else if (write_load) begin
        reg_wen      <= wen_r && (rd_r != 5'd0);
        commit_valid <= 1'b1;
        waddr        <= rd_r;
        wdata        <= load_data;
        commit_pc    <= pc_r;
      end
      pend_valid <= pend_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_23060332_wbu.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_23060332_wbu
// Purpose  : Self-checking bench for the write-back unit. Table of retiring
//            instructions with expected write-port results, plus hand-written
//            sequences for hazard tracking, rd=0 and reset during a load.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_23060332_wbu;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] JUNK     = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_rd = 5'd0;
  logic        in_wen = 1'b0;
  logic        in_is_load = 1'b0;
  logic [2:0]  in_load_op = 3'd0;
  logic [1:0]  in_addr_lo = 2'd0;
  logic [31:0] in_alu_data = 32'd0;
  logic [31:0] in_pc = 32'd0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        reg_wen;
  logic        commit_valid;
  logic [31:0] commit_pc;
  logic        pend_valid;
  logic [4:0]  pend_rd;

  ysyx_23060332_wbu #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_wen(in_wen), .in_is_load(in_is_load),
    .in_load_op(in_load_op), .in_addr_lo(in_addr_lo),
    .in_alu_data(in_alu_data), .in_pc(in_pc),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .waddr(waddr), .wdata(wdata), .reg_wen(reg_wen),
    .commit_valid(commit_valid), .commit_pc(commit_pc),
    .pend_valid(pend_valid), .pend_rd(pend_rd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_load;
    logic [2:0]  op;
    logic [1:0]  alo;
    logic [4:0]  rd;
    logic        wen;
    logic [31:0] alu;
    logic [31:0] pc;
    logic [31:0] rdata;
    int          rvd;
    logic [31:0] exp_wdata;
    logic        exp_wen;
  } vec_t;

  typedef struct {
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        wen;
    logic [31:0] pc;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   fails  = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every commit pulse must match the oldest expectation,
  // including the cycle it was due.
  always @(negedge clk) begin
    if (rst === 1'b1 && commit_valid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL commit: unexpected commit pc=%h waddr=%0d wdata=%h", commit_pc, waddr, wdata);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (waddr !== e.waddr || wdata !== e.wdata || reg_wen !== e.wen ||
            commit_pc !== e.pc || cyc != e.cyc) begin
          fails++;
          $display("FAIL commit: got waddr=%0d wdata=%h wen=%b pc=%h cyc=%0d expected waddr=%0d wdata=%h wen=%b pc=%h cyc=%0d",
                   waddr, wdata, reg_wen, commit_pc, cyc, e.waddr, e.wdata, e.wen, e.pc, e.cyc);
        end
      end
    end
  end

  // Drive one instruction from posedge+1. Loads get their rvalid rvd cycles
  // after accept (rvd < 0: never). A junk rvalid is driven in the accept
  // cycle, which the DUT must ignore.
  task automatic send(input vec_t v, output int waited);
    exp_t e;
    waited      = 0;
    in_valid    = 1'b1;
    in_rd       = v.rd;
    in_wen      = v.wen;
    in_is_load  = v.is_load;
    in_load_op  = v.op;
    in_addr_lo  = v.alo;
    in_alu_data = v.alu;
    in_pc       = v.pc;
    mem_rvalid  = 1'b1;
    mem_rdata   = JUNK;
    while (!in_ready && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready) begin
      check("accept_timeout", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b0;
      mem_rvalid = 1'b0;
      return;
    end
    if (!v.is_load) begin
      e.waddr = v.rd; e.wdata = v.exp_wdata; e.wen = v.exp_wen; e.pc = v.pc; e.cyc = cyc + 1;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    in_valid   = 1'b0;
    mem_rvalid = 1'b0;
    if (v.is_load && v.rvd >= 1) begin
      repeat (v.rvd - 1) begin
        check("load_wait_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
      end
      check("load_wait_ready", {31'd0, in_ready}, 32'd0);
      mem_rvalid = 1'b1;
      mem_rdata  = v.rdata;
      e.waddr = v.rd; e.wdata = v.exp_wdata; e.wen = v.exp_wen; e.pc = v.pc; e.cyc = cyc + 1;
      sb.push_back(e);
      @(posedge clk); #1;
      mem_rvalid = 1'b0;
      mem_rdata  = JUNK;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vt[13];
    vec_t v;
    int   w;

    //        ld  op      alo   rd  wen alu            pc             rdata          rvd exp_wdata     exp_wen
    vt[0]  = '{0, 3'b000, 2'd0, 5,  1, 32'h1234_5678, 32'h8000_0000, 32'h0,         0, 32'h1234_5678, 1};
    vt[1]  = '{1, 3'b000, 2'd3, 10, 1, 32'h5555_5555, 32'h8000_0004, 32'h80FF_0000, 2, 32'hFFFF_FF80, 1};
    vt[2]  = '{1, 3'b100, 2'd3, 11, 1, 32'h5555_5555, 32'h8000_0008, 32'h80FF_0000, 2, 32'h0000_0080, 1};
    vt[3]  = '{1, 3'b101, 2'd2, 12, 1, 32'h5555_5555, 32'h8000_000C, 32'h80FF_0000, 2, 32'h0000_80FF, 1};
    vt[4]  = '{1, 3'b001, 2'd2, 13, 1, 32'h5555_5555, 32'h8000_0010, 32'h80FF_0000, 1, 32'hFFFF_80FF, 1};
    vt[5]  = '{1, 3'b001, 2'd1, 14, 1, 32'h5555_5555, 32'h8000_0014, 32'h1234_8001, 2, 32'hFFFF_8001, 1};
    vt[6]  = '{1, 3'b010, 2'd0, 15, 1, 32'h5555_5555, 32'h8000_0018, 32'hCAFE_BABE, 3, 32'hCAFE_BABE, 1};
    vt[7]  = '{1, 3'b011, 2'd2, 16, 1, 32'h5555_5555, 32'h8000_001C, 32'hA5A5_5A5A, 1, 32'hA5A5_5A5A, 1};
    vt[8]  = '{1, 3'b000, 2'd1, 17, 1, 32'h5555_5555, 32'h8000_0020, 32'h0000_7F00, 2, 32'h0000_007F, 1};
    vt[9]  = '{0, 3'b000, 2'd0, 9,  0, 32'hFFFF_0000, 32'h8000_0024, 32'h0,         0, 32'hFFFF_0000, 0};
    vt[10] = '{1, 3'b100, 2'd0, 31, 1, 32'h5555_5555, 32'h8000_0028, 32'h1234_56F0, 1, 32'h0000_00F0, 1};
    vt[11] = '{0, 3'b000, 2'd0, 31, 1, 32'hDEAD_BEEF, 32'h8000_002C, 32'h0,         0, 32'hDEAD_BEEF, 1};
    vt[12] = '{1, 3'b101, 2'd3, 18, 1, 32'h5555_5555, 32'h8000_0030, 32'hBEEF_1234, 3, 32'h0000_BEEF, 1};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_reg_wen",      {31'd0, reg_wen},      32'd0);
    check("rst_commit_valid", {31'd0, commit_valid}, 32'd0);
    check("rst_pend_valid",   {31'd0, pend_valid},   32'd0);
    check("rst_waddr",        {27'd0, waddr},        32'd0);
    check("rst_pend_rd",      {27'd0, pend_rd},      32'd0);
    check("rst_wdata",        wdata,                 32'd0);
    check("rst_commit_pc",    commit_pc,             RESET_PC);
    rst = 1'b1;
    check("rst_in_ready",     {31'd0, in_ready},     32'd1);

    // Table of instructions, issued back-to-back where possible
    for (int i = 0; i < 13; i++) begin
      send(vt[i], w);
    end
    repeat (3) @(posedge clk);
    #1;

    // Three back-to-back ALU ops: no stall, consecutive commits
    for (int i = 1; i <= 3; i++) begin
      v = '{0, 3'b000, 2'd0, 5'(i), 1, 32'h1000_0000 + 32'(i), 32'h8000_0100 + 32'(4 * i), 32'h0, 0,
            32'h1000_0000 + 32'(i), 1};
      send(v, w);
      check("b2b_no_stall", 32'(w), 32'd0);
    end
    @(posedge clk); #1;

    // rd=0 with wen=1: commit but no write, never pending
    v = '{0, 3'b000, 2'd0, 0, 1, 32'h0BAD_F00D, 32'h8000_0200, 32'h0, 0, 32'h0BAD_F00D, 0};
    send(v, w);
    check("rd0_pend_write",   {31'd0, pend_valid}, 32'd0);
    @(posedge clk); #1;
    check("rd0_pend_after",   {31'd0, pend_valid}, 32'd0);

    // Load to rd=7: pending from the cycle after accept through WRITE
    in_valid = 1'b1; in_rd = 5'd7; in_wen = 1'b1; in_is_load = 1'b1;
    in_load_op = 3'b010; in_addr_lo = 2'd0; in_alu_data = JUNK; in_pc = 32'h8000_0300;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("pend_wait1_valid", {31'd0, pend_valid}, 32'd1);
    check("pend_wait1_rd",    {27'd0, pend_rd},    32'd7);
    @(posedge clk); #1;
    check("pend_wait2_valid", {31'd0, pend_valid}, 32'd1);
    check("pend_wait2_rd",    {27'd0, pend_rd},    32'd7);
    mem_rvalid = 1'b1; mem_rdata = 32'h7777_0007;
    sb.push_back('{5'd7, 32'h7777_0007, 1'b1, 32'h8000_0300, cyc + 1});
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    check("pend_write_valid", {31'd0, pend_valid}, 32'd1);
    check("pend_write_rd",    {27'd0, pend_rd},    32'd7);
    @(posedge clk); #1;
    check("pend_idle_valid",  {31'd0, pend_valid}, 32'd0);

    // Reset during WAIT_LOAD abandons the load; late rvalid is ignored
    v = '{1, 3'b010, 2'd0, 20, 1, JUNK, 32'h8000_0400, 32'h0, -1, 32'h0, 1};
    send(v, w);
    check("abort_waiting",    {31'd0, in_ready}, 32'd0);
    #2 rst = 1'b0;
    #1;
    check("abort_commit_pc",  commit_pc,          RESET_PC);
    check("abort_ready_rst",  {31'd0, in_ready},  32'd1);
    check("abort_pend_rst",   {31'd0, pend_valid}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("abort_no_write", {30'd0, reg_wen, commit_valid}, 32'd0);
      @(posedge clk); #1;
    end
    check("abort_pc_after",   commit_pc,          RESET_PC);
    check("abort_ready_after", {31'd0, in_ready}, 32'd1);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
